// File: rtl/sgnmag_bcd_seq_if.sv
// Stream bundle for the sign/magnitude-to-BCD sequencer.
// The sample side (in_*) and the result side (out_*, busy) travel together.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface sgnmag_bcd_seq_if #(
  parameter int IN_W   = 18,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]     in_data;
  logic                in_valid;
  logic                in_ready;
  logic                out_sign;
  logic [4*DIGITS-1:0] out_bcd;
  logic [3:0]          out_tenth;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sign, out_bcd, out_tenth, out_valid, busy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sign, out_bcd, out_tenth, out_valid, busy
  );
endinterface

// File: rtl/sgnmag_bcd_seq.sv
// Signed Q13.4 sample to display digits: sign, DIGITS BCD integer digits and
// one BCD tenths digit, using an iterative shift-add-3 conversion.
//
//   state | meaning
//   IDLE  | waiting for a sample, in_ready high
//   MAG   | form sign/magnitude, split integer and fraction, clear BCD
//   DAB   | one add-3/shift step per cycle, INT_W cycles
//   FRAC  | tenths digit, register all outputs
//   DONE  | result offered, held until out_ready
module sgnmag_bcd_seq #(
  parameter int IN_W   = 18,
  parameter int FRAC_W = 4,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sgnmag_bcd_seq_if.slave   bus
);

  localparam int INT_W  = IN_W - 1 - FRAC_W;
  localparam int MAG_W  = IN_W - 1;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(INT_W);
  localparam int PROD_W = FRAC_W + 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAG  = 3'd1;
  localparam logic [2:0] S_DAB  = 3'd2;
  localparam logic [2:0] S_FRAC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IN_W-1:0]   data_q;
  logic              sign_q;
  logic [INT_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_sign_q;
  logic [BCD_W-1:0]  out_bcd_q;
  logic [3:0]        out_tenth_q;

  logic              accept;
  logic              last_step;
  logic [MAG_W-1:0]  mag_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [INT_W-1:0]  int_shift;
  logic [3:0]        tenth_d;
  logic              result_zero;

  assign accept    = bus.in_valid && (state_q == S_IDLE);
  assign last_step = (cnt_q == CNT_W'(INT_W - 1));

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MAG;
      S_MAG:   state_d = S_DAB;
      S_DAB:   if (last_step) state_d = S_FRAC;
      S_FRAC:  state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Magnitude of the captured sample; the most negative code has no positive
  // twin, so it saturates to all-ones instead of wrapping to zero
  always_comb begin
    mag_d = data_q[MAG_W-1:0];
    if (data_q[IN_W-1]) begin
      if (data_q[MAG_W-1:0] == '0) mag_d = '1;
      else                         mag_d = ~data_q[MAG_W-1:0] + 1'b1;
    end
  end

  // Add-3 correction on every nibble, then the combined left shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift    = bcd_adj << 1;
    bcd_shift[0] = int_q[INT_W-1];
    int_shift    = int_q << 1;
  end

  // Tenths digit is floor(frac*10 / 2**FRAC_W); a zero result drops the sign
  assign tenth_d     = 4'(({{4{1'b0}}, frac_q} * PROD_W'(10)) >> FRAC_W);
  assign result_zero = (bcd_q == '0) && (tenth_d == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture, sign/magnitude split and the iterative conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sign_q <= 1'b0;
      int_q  <= '0;
      frac_q <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) data_q <= bus.in_data;
        S_MAG: begin
          sign_q <= data_q[IN_W-1];
          int_q  <= mag_d[MAG_W-1:FRAC_W];
          frac_q <= mag_d[FRAC_W-1:0];
          bcd_q  <= '0;
          cnt_q  <= '0;
        end
        S_DAB: begin
          bcd_q <= bcd_shift;
          int_q <= int_shift;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers, loaded only on the FRAC->DONE edge and held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign_q  <= 1'b0;
      out_bcd_q   <= '0;
      out_tenth_q <= '0;
    end else if (state_q == S_FRAC) begin
      out_sign_q  <= sign_q && !result_zero;
      out_bcd_q   <= bcd_q;
      out_tenth_q <= tenth_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sign  = out_sign_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_tenth = out_tenth_q;

endmodule
